// File: rtl/modarith_arbiter_pkg.sv
// Shared types and constants for the modular add/sub arbiter.
package modarith_arbiter_pkg;

  localparam int unsigned DATAWIDTH = 16;
  localparam logic [DATAWIDTH-1:0] P_MOD = 16'd65521;

  localparam logic OP_SUB = 1'b0;
  localparam logic OP_ADD = 1'b1;

  // Command latched from the winning requester and presented to the unit.
  typedef struct packed {
    logic                 op;
    logic [DATAWIDTH-1:0] a;
    logic [DATAWIDTH-1:0] b;
  } unit_cmd_t;

endpackage

// File: rtl/modarith_arbiter_if.sv
// Requester bus and arithmetic-unit handshake of the modular add/sub arbiter.
interface modarith_arbiter_if #(
  parameter int unsigned NREQ = 4
);
  import modarith_arbiter_pkg::*;

  logic [NREQ-1:0]           req;
  logic [NREQ-1:0]           req_op;
  logic [NREQ*DATAWIDTH-1:0] req_a;
  logic [NREQ*DATAWIDTH-1:0] req_b;
  logic [NREQ-1:0]           grant;
  logic [NREQ-1:0]           done;
  logic [DATAWIDTH-1:0]      result;
  logic                      err;
  logic                      busy;
  logic                      unit_enable;
  logic                      unit_op;
  logic [DATAWIDTH-1:0]      unit_a;
  logic [DATAWIDTH-1:0]      unit_b;
  logic [DATAWIDTH-1:0]      unit_result;
  logic                      unit_ready;

  modport slave (
    input  req, req_op, req_a, req_b, unit_result, unit_ready,
    output grant, done, result, err, busy, unit_enable, unit_op, unit_a, unit_b
  );

  modport master (
    output req, req_op, req_a, req_b, unit_result, unit_ready,
    input  grant, done, result, err, busy, unit_enable, unit_op, unit_a, unit_b
  );

endinterface

// File: rtl/modarith_arbiter_rr_priority_pick.sv
// Combinational round-robin picker: first set req bit after position last, wrapping.
module modarith_arbiter_rr_priority_pick #(
  parameter int unsigned NREQ = 4
) (
  input  logic [NREQ-1:0]         req,
  input  logic [$clog2(NREQ)-1:0] last,
  output logic [NREQ-1:0]         pick_c,
  output logic                    valid_c
);

  localparam int unsigned IW = $clog2(NREQ);

  logic          found;
  logic [IW-1:0] idx;

  always_comb begin
    pick_c  = '0;
    valid_c = |req;
    found   = 1'b0;
    idx     = '0;
    // Offset 1..NREQ so the previous owner is considered last.
    for (int unsigned k = 1; k <= NREQ; k++) begin
      idx = IW'((32'(last) + k) % NREQ);
      if (!found && req[idx]) begin
        pick_c[idx] = 1'b1;
        found       = 1'b1;
      end
    end
  end

endmodule

// File: rtl/modarith_arbiter.sv
// Round-robin sequencer sharing one modular add/sub unit among NREQ requesters,
// with a timeout guard against a unit that never raises ready.
module modarith_arbiter #(
  parameter int unsigned NREQ    = 4,
  parameter int unsigned TIMEOUT = 15
) (
  input  logic              clk,
  input  logic              reset,
  modarith_arbiter_if.slave bus
);
  import modarith_arbiter_pkg::*;

  localparam int unsigned IW = $clog2(NREQ);
  localparam int unsigned CW = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_BLANK,
    ST_WAIT,
    ST_DONE
  } state_e;

  state_e               state_q, state_d;
  logic [NREQ-1:0]      grant_q, grant_d;
  logic [NREQ-1:0]      done_q, done_d;
  logic                 err_q, err_d;
  logic                 busy_q, busy_d;
  logic                 enable_q, enable_d;
  unit_cmd_t            cmd_q, cmd_d;
  logic [DATAWIDTH-1:0] result_q, result_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [IW-1:0]        last_q, last_d;

  logic [NREQ-1:0]      pick_c;
  logic                 pick_valid_c;
  unit_cmd_t            sel_cmd_c;
  logic [IW-1:0]        owner_idx_c;

  modarith_arbiter_rr_priority_pick #(.NREQ(NREQ)) u_pick (
    .req     (bus.req),
    .last    (last_q),
    .pick_c  (pick_c),
    .valid_c (pick_valid_c)
  );

  // Operand/op mux from the one-hot pick.
  always_comb begin
    sel_cmd_c = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (pick_c[i]) begin
        sel_cmd_c.op = bus.req_op[i];
        sel_cmd_c.a  = bus.req_a[i*DATAWIDTH +: DATAWIDTH];
        sel_cmd_c.b  = bus.req_b[i*DATAWIDTH +: DATAWIDTH];
      end
    end
  end

  always_comb begin
    owner_idx_c = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (grant_q[i]) owner_idx_c = IW'(i);
    end
  end

  always_comb begin
    state_d  = state_q;
    grant_d  = grant_q;
    done_d   = '0;
    err_d    = err_q;
    enable_d = 1'b0;
    cmd_d    = cmd_q;
    result_d = result_q;
    cnt_d    = cnt_q;
    last_d   = last_q;

    case (state_q)
      ST_IDLE: begin
        if (pick_valid_c) begin
          grant_d  = pick_c;
          cmd_d    = sel_cmd_c;
          enable_d = 1'b1;
          state_d  = ST_ISSUE;
        end
      end
      ST_ISSUE: state_d = ST_BLANK;
      // Ready left over from the previous operation may still be high here.
      ST_BLANK: begin
        cnt_d   = '0;
        state_d = ST_WAIT;
      end
      ST_WAIT: begin
        if (bus.unit_ready) begin
          result_d = bus.unit_result;
          err_d    = 1'b0;
          done_d   = grant_q;
          state_d  = ST_DONE;
        end else if (32'(cnt_q) + 32'd1 >= TIMEOUT) begin
          result_d = '0;
          err_d    = 1'b1;
          done_d   = grant_q;
          state_d  = ST_DONE;
        end else if (cnt_q != '1) begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_DONE: begin
        last_d  = owner_idx_c;
        grant_d = '0;
        err_d   = 1'b0;
        cnt_d   = '0;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      grant_q  <= '0;
      done_q   <= '0;
      err_q    <= 1'b0;
      busy_q   <= 1'b0;
      enable_q <= 1'b0;
      cmd_q    <= '{op: OP_SUB, a: '0, b: '0};
      result_q <= '0;
      cnt_q    <= '0;
      last_q   <= IW'(NREQ - 1);
    end else begin
      state_q  <= state_d;
      grant_q  <= grant_d;
      done_q   <= done_d;
      err_q    <= err_d;
      busy_q   <= busy_d;
      enable_q <= enable_d;
      cmd_q    <= cmd_d;
      result_q <= result_d;
      cnt_q    <= cnt_d;
      last_q   <= last_d;
    end
  end

  assign bus.grant       = grant_q;
  assign bus.done        = done_q;
  assign bus.err         = err_q;
  assign bus.busy        = busy_q;
  assign bus.result      = result_q;
  assign bus.unit_enable = enable_q;
  assign bus.unit_op     = cmd_q.op;
  assign bus.unit_a      = cmd_q.a;
  assign bus.unit_b      = cmd_q.b;

endmodule

// File: doc/modarith_arbiter.md
Name: modarith_arbiter

Overview:
- Round-robin arbiter and sequencer that shares one modular add/subtract unit (modSubtraction plus its modAddition sibling, muxed) among NREQ requesters, e.g. point-add and point-double sequencers of the ECEG core.
- Latches the winner's operands and op, pulses the unit's enable, waits for the unit's ready, then returns the result with a one-cycle done strobe to the winner.
- Adds a timeout guard so a hung unit cannot lock the arbiter.

Parameters:
- DATAWIDTH, `DATAWIDTH, operand/result width (field element width).
- NREQ, 4, number of requesters (2..8).
- TIMEOUT, 15, maximum WAIT cycles before abort.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- req  input  NREQ  per-requester request level; held until own done.
- req_op  input  NREQ  per-requester op: 0 = a-b mod p, 1 = a+b mod p.
- req_a  input  NREQ*DATAWIDTH  packed operand a; requester i at bits [i*DATAWIDTH +: DATAWIDTH].
- req_b  input  NREQ*DATAWIDTH  packed operand b, same packing.
- grant  output  NREQ  one-hot current owner; 0 when idle.
- done  output  NREQ  one-cycle strobe to the owner when result is valid.
- result  output  DATAWIDTH  registered result; valid in the done cycle, held until the next done.
- err  output  1  high with done when the transaction timed out.
- busy  output  1  high in every state except IDLE.
- unit_enable  output  1  one-cycle start pulse to the arithmetic unit.
- unit_op  output  1  op select to the unit mux.
- unit_a  output  DATAWIDTH  latched operand a.
- unit_b  output  DATAWIDTH  latched operand b.
- unit_result  input  DATAWIDTH  unit result.
- unit_ready  input  1  unit outputReady level.

Behaviour:
- Reset (asynchronous, any state):
  - state = IDLE.
  - grant, done, err, busy, unit_enable, unit_op, unit_a, unit_b, result, timeout counter = 0.
  - Round-robin pointer last = NREQ-1, so requester 0 has first priority.
- IDLE:
  - If any req bit is set, pick the first set bit searching last+1, last+2, … (modulo NREQ).
  - Register grant, unit_op, unit_a, unit_b from the winner and go to ISSUE.
  - Decision is made in the cycle req is seen; grant is visible the next cycle.
- ISSUE (1 cycle): unit_enable = 1; go to BLANK.
- BLANK (1 cycle): unit_ready is ignored here because the unit's ready from a prior operation may still be high. Go to WAIT.
- WAIT:
  - When unit_ready = 1: result <= unit_result, err <= 0, go to DONE.
  - Otherwise increment the counter.
  - When the counter reaches TIMEOUT with no ready: result <= 0, err <= 1, go to DONE.
- DONE (1 cycle):
  - done[owner] = 1; err is valid in this cycle.
  - last <= owner; grant <= 0; go to IDLE.
- grant is stable from ISSUE through DONE inclusive.
- Operands are captured only in IDLE; requester changes after grant have no effect.
- Latency with a standard 2-cycle unit: req seen to done = 5 cycles (IDLE, ISSUE, BLANK, WAIT, DONE). Back-to-back throughput is one operation per 5 cycles; a new arbitration happens in the IDLE cycle after DONE.
- Simultaneous requests: rotating priority only. No requester waits more than NREQ-1 transactions.
- A requester dropping req before done (illegal): the transaction still completes and done is still pulsed.
- A req bit set in the DONE cycle is considered in the following IDLE cycle.
- Width rules:
  - All operand and result paths are exactly DATAWIDTH; the arbiter does no arithmetic.
  - The counter is $clog2(TIMEOUT+1) bits and saturates.
- Reset mid-transaction aborts silently: no done pulse, pointer returns to NREQ-1.

Decomposition:
- Shared package / parameters.vh: `DATAWIDTH, `p, and op encodings OP_SUB = 1'b0, OP_ADD = 1'b1.
- State encodings IDLE/ISSUE/BLANK/WAIT/DONE are localparams in the module.
- One sub-module, rr_priority_pick: combinational NREQ-bit round-robin picker; inputs req and last; outputs a one-hot pick and a valid flag.

Test Plan:
- Single sub: req=0001, a=5, b=9 -> grant=0001 one cycle later, unit_enable pulse, done=0001 at cycle 5, result = p-4, err=0.
- Single add: req=0100, op=1, a=p-1, b=3 -> done=0100, result=2, busy low the cycle after done.
- Contention: req=1111 held, each requester dropping its req after its done -> grant order 0001, 0010, 0100, 1000; next grant after re-requesting 0001 is 0001.
- Fairness wrap: last=2 (requester 2 served), then req=0101 -> requester 0 is not skipped; grant goes to 0001 before 0100.
- Timeout: tie unit_ready low -> done after TIMEOUT WAIT cycles (15), err=1, result=0; the next request completes normally.
- Async reset: assert reset during WAIT -> grant, busy, unit_enable drop immediately without a clock; no done pulse; the next req=0010 is served with 5-cycle latency.
